// File: rtl/mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin select-mux arbiter.
// Seven requesters, 3-bit select, 3'b111 means no unit owns the mux.
package mux_arb_pkg;

   localparam int N_REQ = 7;
   localparam logic [2:0] SEL_IDLE = 3'b111;

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   function automatic logic [N_REQ-1:0] idx_to_onehot(
      input logic [2:0] idx
   );
      logic [N_REQ-1:0] one;
      one = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (idx == 3'(i)) one[i] = 1'b1;
      end
      return one;
   endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Request/grant bundle between the datapath units and the arbiter.
// master = unit side (drives req), slave = arbiter side.
interface mux_arbiter_if
   import mux_arb_pkg::*;
#(
   parameter int CNT_W = 8
);

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic [2:0]       sel;
   logic             busy;
   logic [CNT_W-1:0] hold_cnt;

   modport master (
      output req,
      input  gnt,
      input  sel,
      input  busy,
      input  hold_cnt
   );

   modport slave (
      input  req,
      output gnt,
      output sel,
      output busy,
      output hold_cnt
   );

endinterface

// File: rtl/mux_arbiter_rr_pick7.sv
// Combinational round-robin picker over seven requests.
// Searches last+1, last+2, ... modulo 7 among req & mask.
module rr_pick7
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [2:0]       last,
   input  logic [N_REQ-1:0] mask,
   output logic             found,
   output logic [2:0]       idx
);

   logic [N_REQ-1:0] cand;
   int               pos;
   logic [2:0]       p3;

   assign cand = req & mask;

   // first candidate after the last winner, wrapping at 7
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = 0;
      p3    = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         pos = int'(last) + k;
         if (pos >= N_REQ) pos = pos - N_REQ;
         p3 = 3'(pos);
         if (!found && cand[p3]) begin
            found = 1'b1;
            idx   = p3;
         end
      end
   end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter for the shared 7:1 18-bit operand/result mux.
// Registered one-hot grant and select, bounded hold with forced handover.
module mux_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
)(
   input logic        clk,
   input logic        rst,
   mux_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state;
   state_t           state_n;
   logic [N_REQ-1:0] gnt;
   logic [N_REQ-1:0] gnt_n;
   logic [2:0]       sel;
   logic [2:0]       sel_n;
   logic             busy;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic [2:0]       last;
   logic [2:0]       last_n;

   logic             hold_req;
   logic             others;
   logic             forced;
   logic [N_REQ-1:0] mask;
   logic             found;
   logic [2:0]       idx;

   // the current grant vector doubles as the holder's one-hot mask
   assign hold_req = |(bus.req & gnt);
   assign others   = |(bus.req & ~gnt);
   assign forced   = (state == GRANT) && hold_req &&
                     (cnt == HOLD_LAST) && others;
   assign mask     = forced ? ~gnt : '1;

   rr_pick7 u_pick (
      .req   (bus.req),
      .last  (last),
      .mask  (mask),
      .found (found),
      .idx   (idx)
   );

   // next-state: grant, release, forced handover or keep
   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      sel_n   = sel;
      cnt_n   = cnt;
      last_n  = last;
      unique case (state)
         IDLE: begin
            if (found) begin
               state_n = GRANT;
               gnt_n   = idx_to_onehot(idx);
               sel_n   = idx;
               last_n  = idx;
               cnt_n   = '0;
            end
         end
         GRANT: begin
            if (!hold_req) begin
               if (found) begin
                  gnt_n  = idx_to_onehot(idx);
                  sel_n  = idx;
                  last_n = idx;
                  cnt_n  = '0;
               end else begin
                  state_n = IDLE;
                  gnt_n   = '0;
                  sel_n   = SEL_IDLE;
                  cnt_n   = '0;
               end
            end else if (forced) begin
               gnt_n  = idx_to_onehot(idx);
               sel_n  = idx;
               last_n = idx;
               cnt_n  = '0;
            end else if (cnt != HOLD_LAST) begin
               cnt_n = cnt + 1'b1;
            end
         end
      endcase
   end

   // all outputs are flops; reset parks the pointer so unit 0 wins first
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= '0;
         sel   <= SEL_IDLE;
         busy  <= 1'b0;
         cnt   <= '0;
         last  <= 3'd6;
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         sel   <= sel_n;
         busy  <= |gnt_n;
         cnt   <= cnt_n;
         last  <= last_n;
      end
   end

   assign bus.gnt      = gnt;
   assign bus.sel      = sel;
   assign bus.busy     = busy;
   assign bus.hold_cnt = cnt;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: vector table on a MAX_HOLD=8 instance,
// plus a rotation sequence on a MAX_HOLD=4 instance.
module tb_mux_arbiter;
   import mux_arb_pkg::*;

   typedef struct {
      logic       rst;
      logic [6:0] req;
      logic [6:0] gnt;
      logic [2:0] sel;
      logic       busy;
      logic [7:0] cnt;
      string      tag;
   } vec_t;

   logic clk = 1'b0;
   logic rst8;
   logic rst4;

   int   n_chk  = 0;
   int   n_fail = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   mux_arbiter_if #(.CNT_W(8)) bus8 ();
   mux_arbiter_if #(.CNT_W(8)) bus4 ();

   mux_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut8 (
      .clk (clk),
      .rst (rst8),
      .bus (bus8)
   );

   mux_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut4 (
      .clk (clk),
      .rst (rst4),
      .bus (bus4)
   );

   function automatic void add(
      input string      t,
      input logic       r,
      input logic [6:0] q,
      input logic [6:0] g,
      input logic [2:0] s,
      input logic       b,
      input logic [7:0] c
   );
      vec_t v;
      v.tag  = t;
      v.rst  = r;
      v.req  = q;
      v.gnt  = g;
      v.sel  = s;
      v.busy = b;
      v.cnt  = c;
      vecs.push_back(v);
   endfunction

   task automatic check(
      input string      t,
      input logic [6:0] g,
      input logic [2:0] s,
      input logic       b,
      input logic [7:0] c,
      input logic [6:0] eg,
      input logic [2:0] es,
      input logic       eb,
      input logic [7:0] ec
   );
      n_chk++;
      if ({g, s, b, c} !== {eg, es, eb, ec}) begin
         n_fail++;
         $display("FAIL %s: got gnt=%h sel=%0d busy=%b cnt=%0d, want gnt=%h sel=%0d busy=%b cnt=%0d",
                  t, g, s, b, c, eg, es, eb, ec);
      end
   endtask

   initial begin
      rst8     = 1'b1;
      rst4     = 1'b1;
      bus8.req = '0;
      bus4.req = '0;

      // reset with everyone requesting, then unit 0 first
      add("rst0", 1, 7'h7F, 7'h00, 3'd7, 0, 0);
      add("rst1", 1, 7'h7F, 7'h00, 3'd7, 0, 0);
      add("first", 0, 7'h7F, 7'h01, 3'd0, 1, 0);
      // unit 0 releases, unit 4 alone for 20 cycles
      add("single", 0, 7'h10, 7'h10, 3'd4, 1, 0);
      for (int k = 1; k < 20; k++)
         add("sat", 0, 7'h10, 7'h10, 3'd4, 1, (k < 7) ? 8'(k) : 8'd7);
      add("drop", 0, 7'h00, 7'h00, 3'd7, 0, 0);
      // zero-bubble handover 2 -> 5
      add("g2", 0, 7'h04, 7'h04, 3'd2, 1, 0);
      add("g2w5", 0, 7'h24, 7'h04, 3'd2, 1, 1);
      add("hand5", 0, 7'h20, 7'h20, 3'd5, 1, 0);
      // release with 0,1 newly arriving: wrap 6 -> 0
      add("wrap0", 0, 7'h03, 7'h01, 3'd0, 1, 0);
      // unit 3 to hold_cnt=2, then mid-grant reset
      add("g3a", 0, 7'h08, 7'h08, 3'd3, 1, 0);
      add("g3b", 0, 7'h08, 7'h08, 3'd3, 1, 1);
      add("g3c", 0, 7'h08, 7'h08, 3'd3, 1, 2);
      add("midrst", 1, 7'h08, 7'h00, 3'd7, 0, 0);
      add("after", 0, 7'h48, 7'h08, 3'd3, 1, 0);
      // unit 6 waits; forced handover after 8 cycles
      for (int k = 1; k < 8; k++)
         add("hold3", 0, 7'h48, 7'h08, 3'd3, 1, 8'(k));
      add("force6", 0, 7'h48, 7'h40, 3'd6, 1, 0);
      add("keep6", 0, 7'h48, 7'h40, 3'd6, 1, 1);
      add("rel6", 0, 7'h08, 7'h08, 3'd3, 1, 0);
      add("idle", 0, 7'h00, 7'h00, 3'd7, 0, 0);

      foreach (vecs[i]) begin
         rst8     = vecs[i].rst;
         bus8.req = vecs[i].req;
         @(posedge clk);
         #1;
         check(vecs[i].tag, bus8.gnt, bus8.sel, bus8.busy,
               bus8.hold_cnt, vecs[i].gnt, vecs[i].sel,
               vecs[i].busy, vecs[i].cnt);
      end

      // fairness: all request, MAX_HOLD=4, rotation 0..6,0
      rst4     = 1'b1;
      bus4.req = 7'h7F;
      @(posedge clk);
      #1;
      check("f_rst", bus4.gnt, bus4.sel, bus4.busy,
            bus4.hold_cnt, 7'h00, 3'd7, 1'b0, 8'd0);
      rst4 = 1'b0;
      for (int t = 0; t < 32; t++) begin
         logic [2:0] u;
         logic [6:0] eg;
         u  = 3'((t / 4) % 7);
         eg = 7'h01 << u;
         @(posedge clk);
         #1;
         check("fair", bus4.gnt, bus4.sel, bus4.busy,
               bus4.hold_cnt, eg, u, 1'b1, 8'(t % 4));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter that shares the 18-bit, 7-input operand/result select mux among seven requesting datapath units. It grants at most one requester at a time and drives the mux's 3-bit select from the grant. Each grant lasts for a bounded number of cycles, so no unit can starve the others. It sits between the unit request lines and the select input of the 7:1 18-bit mux.

## Interface
Parameters:
- MAX_HOLD, default 8: maximum consecutive grant cycles while another requester waits; legal range 1..255.
- CNT_W, default 8: hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  7  request per unit; bit i = unit i; level-sensitive; held high until the unit is done.
- gnt  out  7  one-hot grant (all-zero when idle), registered.
- sel  out  3  mux select, registered. Grant i drives sel = i (3'b000..3'b110); idle drives 3'b111.
- busy  out  1  high whenever any gnt bit is high.
- hold_cnt  out  CNT_W  cycles the current holder has been granted, minus one; 0 when idle.

## Operation
- FSM states: IDLE and GRANT.
- Reset values: state=IDLE, gnt=0, sel=3'b111, busy=0, hold_cnt=0, rr pointer last=6, so unit 0 has first priority.
- Pick function: from the current req vector, choose the first set bit, searching last+1, last+2, … wrapping modulo 7. The holder is excluded when a forced handover occurs.
- IDLE:
  - If req≠0: grant the picked index p, set last=p, hold_cnt=0, go to GRANT.
  - Otherwise remain idle.
- GRANT, holder h. Evaluated every edge, in this priority order:
  1. req[h]=0 (release): if other requests are pending, grant pick(req) directly with no idle bubble, set last to it, hold_cnt=0. If none are pending, go to IDLE with gnt=0, sel=3'b111.
  2. req[h]=1, hold_cnt==MAX_HOLD-1, and another req pending: forced handover to pick(req & ~(1<<h)), set last, hold_cnt=0. The preempted unit keeps req high and re-competes normally.
  3. Otherwise keep the grant. hold_cnt increments and saturates at MAX_HOLD-1.
- With MAX_HOLD=1, any competition rotates the grant every cycle.
- Simultaneous events:
  - A new request arriving in the same cycle the holder releases is eligible for that edge's pick.
  - Release takes precedence over forced handover.
- Reset mid-grant: the next edge returns all state to its reset values regardless of req. Units must tolerate losing a grant.
- Invariants:
  - gnt is always one-hot or zero.
  - sel==3'b111 exactly when gnt==0.
  - sel equals the index of the set gnt bit.

## Timing
- Grant latency: req sampled high at edge k gives gnt/sel valid after edge k, i.e. one cycle.
- Handover: holder drops req before edge k; the new gnt is visible after edge k. The mux never sees an idle gap between back-to-back requesters.
- gnt, sel, busy and hold_cnt are all flops. There is no combinational path from req to outputs.
- Worst-case wait for a continuously requesting unit: 6·MAX_HOLD + 1 cycles.

## Structure
- Package mux_arb_pkg holds:
  - N_REQ=7
  - SEL_IDLE=3'b111
  - the state enum {IDLE, GRANT}
  - a function idx_to_onehot
- Sub-module rr_pick7 is purely combinational.
  - Inputs: req[6:0], last[2:0], mask[6:0].
  - Outputs: found, idx[2:0].
  - The top module instantiates it once. The exclusion mask is all-ones except on forced handover.

## Test plan
- Reset check: assert rst with req=7'h7F. After release, the first grant is gnt=7'h01, sel=3'b000, arriving one cycle after the first unreset edge. During reset, sel=3'b111.
- Single requester: req=7'h10 held 20 cycles, MAX_HOLD=8. gnt stays 7'h10 and hold_cnt saturates at 7. Dropping req gives gnt=0, sel=3'b111 next cycle.
- Fairness: req=7'h7F constant, MAX_HOLD=4. Grants rotate 0,1,…,6,0, each lasting exactly 4 cycles, with hold_cnt sequence 0,1,2,3.
- Zero-bubble handover: unit 2 granted, unit 5 requesting. Unit 2 drops req. The next cycle shows gnt=7'h20, sel=3'b101, and busy never deasserts.
- Wrap and simultaneity: last=5, holder releases while req=7'h03 newly arrives and unit 6 is not requesting. Grant goes to unit 0 (search 6→0).
- Mid-grant reset: rst pulsed while unit 3 is granted with hold_cnt=2. The next cycle shows gnt=0, sel=3'b111, hold_cnt=0. The following grant with req=7'h48 goes to unit 3 (last reset to 6).
